mc_control_unit: RTL and testbench

//  Multicycle control unit for the ARM-subset core, the successor to the single-cycle decoder.
//  - Sequences each instruction through FETCH/DECODE/EXECUTE/WRITEBACK states.
//  - Handles memory wait states with a MemReady handshake and a timeout.
//  - Adds CMP without writeback, BL, and an illegal-instruction flag.
//  - Drives every datapath mux, enable and ALU select; condition evaluation stays external (CondEx in).

---
 rtl/core_ctrl_pkg.sv | 53 +++++
 rtl/mc_alu_decoder.sv | 44 ++++
 rtl/mc_control_unit.sv | 195 +++++++++++++++++++
 tb/tb_mc_control_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared types and encodings for the multicycle control unit.
// States, ALU op select, DP Funct commands, Op classes and mux encodings.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_MEMADR,
    S_MEMRD,
    S_MEMWR,
    S_MEMWB,
    S_BRANCH
  } state_t;

  typedef enum logic {
    ALUOP_ADD,
    ALUOP_DP
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;

  localparam logic [3:0] DP_ADD = 4'b0100;
  localparam logic [3:0] DP_SUB = 4'b0010;
  localparam logic [3:0] DP_AND = 4'b0000;
  localparam logic [3:0] DP_ORR = 4'b1100;
  localparam logic [3:0] DP_CMP = 4'b1010;
  localparam logic [3:0] DP_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: Funct/ALUOp -> ALU select, flag-write mask, CMP, illegal.
// Ports: funct, aluop in; aluctl, flagw, cmp, illegal out (combinational).
module mc_alu_decoder
  import core_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  alu_op_t    aluop,
  output logic [2:0] aluctl,
  output logic [1:0] flagw,
  output logic       cmp,
  output logic       illegal
);

  logic [3:0] cmd;
  logic       arith;

  assign cmd = funct[4:1];

  always_comb begin
    aluctl  = ALU_ADD;
    flagw   = 2'b00;
    cmp     = 1'b0;
    illegal = 1'b0;
    arith   = 1'b0;
    if (aluop == ALUOP_DP) begin
      case (cmd)
        DP_ADD: begin aluctl = ALU_ADD; arith = 1'b1; end
        DP_SUB: begin aluctl = ALU_SUB; arith = 1'b1; end
        DP_AND: aluctl = ALU_AND;
        DP_ORR: aluctl = ALU_ORR;
        DP_MOV: aluctl = ALU_MOV;
        DP_CMP: begin
          aluctl = ALU_SUB;
          arith  = 1'b1;
          cmp    = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
      // CMP always updates all flags; others follow the S bit
      flagw = cmp ? 2'b11 : {funct[0], funct[0] & arith};
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle FSM control for the ARM-subset core.
// In: clk, reset(n), Op, Funct, Rd, CondEx, MemReady. Out: datapath controls.
module mc_control_unit
  import core_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int WAIT_W    = 4,
  parameter int ENABLE_BL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 CondEx,
  input  logic                 MemReady,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegW,
  output logic                 LinkSel,
  output logic                 MemW,
  output logic                 ByteMem,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           FlagW,
  output logic                 Illegal,
  output logic                 MemFault
);

  // last stalled cycle before the timeout fires (2**WAIT_W-1 total)
  localparam logic [WAIT_W-1:0] LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

  state_t            state;
  logic [WAIT_W-1:0] wcnt;
  logic [2:0]        alu_q;
  logic [1:0]        flw_q;
  logic              cmp_q;
  logic              byte_q;
  logic              ld_q;
  logic              rd15_q;
  logic              link_q;

  alu_op_t           aluop;
  logic [2:0]        dalu;
  logic [1:0]        dflw;
  logic              dcmp;
  logic              dill;
  logic              bad;
  logic              waiting;
  logic              stall;
  logic              tmo;

  assign aluop = (Op == OP_DP) ? ALUOP_DP : ALUOP_ADD;

  mc_alu_decoder u_dec (
    .funct   (Funct),
    .aluop   (aluop),
    .aluctl  (dalu),
    .flagw   (dflw),
    .cmp     (dcmp),
    .illegal (dill)
  );

  assign bad     = (Op == OP_BAD) | dill;
  assign waiting = state inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign stall   = waiting & ~MemReady;
  assign tmo     = stall & (wcnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      wcnt   <= '0;
      alu_q  <= ALU_ADD;
      flw_q  <= 2'b00;
      cmp_q  <= 1'b0;
      byte_q <= 1'b0;
      ld_q   <= 1'b0;
      rd15_q <= 1'b0;
      link_q <= 1'b0;
    end else begin
      wcnt <= (stall && !tmo) ? wcnt + WAIT_W'(1) : '0;
      unique case (state)
        S_FETCH: begin
          if (MemReady) state <= S_DECODE;
        end
        S_DECODE: begin
          alu_q  <= dalu;
          flw_q  <= dflw;
          cmp_q  <= dcmp;
          byte_q <= Funct[2];
          ld_q   <= Funct[0];
          rd15_q <= (Rd == 4'hF);
          link_q <= (ENABLE_BL != 0) && Funct[4];
          if (!CondEx || bad) begin
            state <= S_FETCH;
          end else begin
            unique case (Op)
              OP_DP:   state <= Funct[5] ? S_EXECI : S_EXECR;
              OP_MEM:  state <= S_MEMADR;
              default: state <= S_BRANCH;
            endcase
          end
        end
        S_EXECR, S_EXECI: state <= cmp_q ? S_FETCH : S_ALUWB;
        S_MEMADR: state <= ld_q ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (MemReady) state <= S_MEMWB;
          else if (tmo) state <= S_FETCH;
        end
        S_MEMWR: begin
          if (MemReady || tmo) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // outputs forced low while reset is held so an abort never writes
  always_comb begin
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ImmSrc     = IMM_8;
    RegSrc     = 2'b00;
    RegW       = 1'b0;
    LinkSel    = 1'b0;
    MemW       = 1'b0;
    ByteMem    = 1'b0;
    ALUControl = '0;
    FlagW      = 2'b00;
    Illegal    = 1'b0;
    MemFault   = 1'b0;
    if (reset) begin
      unique case (Op)
        OP_MEM:  ImmSrc = IMM_12;
        OP_BR:   ImmSrc = IMM_24;
        default: ImmSrc = IMM_8;
      endcase
      RegSrc   = {(Op == OP_MEM) & ~Funct[0], Op == OP_BR};
      MemFault = tmo;
      unique case (state)
        S_FETCH: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          IRWrite   = MemReady;
          PCWrite   = MemReady;
        end
        S_DECODE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_FOUR;
          Illegal = CondEx & bad;
        end
        S_EXECR, S_EXECI: begin
          ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_REG;
          ALUControl = ALUCTRL_W'(alu_q);
          FlagW      = flw_q;
        end
        S_ALUWB: begin
          RegW    = 1'b1;
          PCWrite = rd15_q;
        end
        S_MEMADR: ALUSrcB = SRCB_IMM;
        S_MEMRD, S_MEMWR: begin
          AdrSrc  = 1'b1;
          ByteMem = byte_q;
          MemW    = (state == S_MEMWR);
        end
        S_MEMWB: begin
          RegW      = 1'b1;
          ResultSrc = RES_RDATA;
          ByteMem   = byte_q;
          PCWrite   = rd15_q;
        end
        S_BRANCH: begin
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALU;
          PCWrite   = 1'b1;
          RegW      = link_q;
          LinkSel   = link_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: random instruction streams vs a per-instruction
// cycle-script model, on ENABLE_BL=1 and ENABLE_BL=0 instances.
module tb_mc_control_unit;

  typedef struct packed {
    logic       irw;
    logic       pcw;
    logic       adr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] imm;
    logic [1:0] rsrc;
    logic       regw;
    logic       link;
    logic       memw;
    logic       byt;
    logic [2:0] alu;
    logic [1:0] flw;
    logic       ill;
    logic       flt;
  } ctl_t;

  typedef struct packed {
    logic mr;
    ctl_t e1;
    ctl_t e0;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic       CondEx = 1'b0;
  logic       MemReady = 1'b0;

  logic       irw_a, pcw_a, adr_a, sa_a, rw_a, ls_a, mw_a, bm_a, il_a, mf_a;
  logic [1:0] sb_a, rs_a, is_a, rg_a, fw_a;
  logic [2:0] ac_a;
  logic       irw_b, pcw_b, adr_b, sa_b, rw_b, ls_b, mw_b, bm_b, il_b, mf_b;
  logic [1:0] sb_b, rs_b, is_b, rg_b, fw_b;
  logic [2:0] ac_b;

  ctl_t o1, o0;
  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ninstr = 0;

  logic [3:0] legal [6] = '{4'b0100, 4'b0010, 4'b0000,
                            4'b1100, 4'b1010, 4'b1101};

  always #5 clk = ~clk;

  mc_control_unit #(.ALUCTRL_W(3), .WAIT_W(4), .ENABLE_BL(1)) dut1 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .CondEx(CondEx), .MemReady(MemReady),
    .IRWrite(irw_a), .PCWrite(pcw_a), .AdrSrc(adr_a), .ALUSrcA(sa_a),
    .ALUSrcB(sb_a), .ResultSrc(rs_a), .ImmSrc(is_a), .RegSrc(rg_a),
    .RegW(rw_a), .LinkSel(ls_a), .MemW(mw_a), .ByteMem(bm_a),
    .ALUControl(ac_a), .FlagW(fw_a), .Illegal(il_a), .MemFault(mf_a)
  );

  mc_control_unit #(.ALUCTRL_W(3), .WAIT_W(4), .ENABLE_BL(0)) dut0 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .CondEx(CondEx), .MemReady(MemReady),
    .IRWrite(irw_b), .PCWrite(pcw_b), .AdrSrc(adr_b), .ALUSrcA(sa_b),
    .ALUSrcB(sb_b), .ResultSrc(rs_b), .ImmSrc(is_b), .RegSrc(rg_b),
    .RegW(rw_b), .LinkSel(ls_b), .MemW(mw_b), .ByteMem(bm_b),
    .ALUControl(ac_b), .FlagW(fw_b), .Illegal(il_b), .MemFault(mf_b)
  );

  assign o1 = {irw_a, pcw_a, adr_a, sa_a, sb_a, rs_a, is_a, rg_a,
               rw_a, ls_a, mw_a, bm_a, ac_a, fw_a, il_a, mf_a};
  assign o0 = {irw_b, pcw_b, adr_b, sa_b, sb_b, rs_b, is_b, rg_b,
               rw_b, ls_b, mw_b, bm_b, ac_b, fw_b, il_b, mf_b};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ALU table straight from the instruction set description
  task automatic ref_alu(input logic [5:0] fn, output logic [2:0] alu,
                         output logic [1:0] flw, output logic cmp,
                         output logic ok);
    logic s;
    s   = fn[0];
    cmp = 1'b0;
    ok  = 1'b1;
    alu = 3'd0;
    flw = 2'b00;
    case (fn[4:1])
      4'b0100: begin alu = 3'd0; flw = {s, s}; end
      4'b0010: begin alu = 3'd1; flw = {s, s}; end
      4'b0000: begin alu = 3'd2; flw = {s, 1'b0}; end
      4'b1100: begin alu = 3'd3; flw = {s, 1'b0}; end
      4'b1101: begin alu = 3'd4; flw = {s, 1'b0}; end
      4'b1010: begin alu = 3'd1; flw = 2'b11; cmp = 1'b1; end
      default: ok = 1'b0;
    endcase
  endtask

  function automatic ctl_t base();
    ctl_t c;
    c = '0;
    c.imm  = (Op == 2'b01) ? 2'b01 : (Op == 2'b10) ? 2'b10 : 2'b00;
    c.rsrc = {(Op == 2'b01) && !Funct[0], Op == 2'b10};
    return c;
  endfunction

  task automatic push(input ctl_t a, input ctl_t b);
    ent_t e;
    e.mr = 1'($urandom_range(0, 1));
    e.e1 = a;
    e.e0 = b;
    q.push_back(e);
  endtask

  // kind 0 fetch, 1 read, 2 write; st>=15 means timeout
  task automatic mem_phase(input int kind, input int st, output bit to);
    ent_t e;
    ctl_t c;
    int   n;
    to = (st >= 15);
    n  = to ? 15 : st + 1;
    for (int i = 0; i < n; i++) begin
      e.mr = !to && (i == n - 1);
      c = base();
      if (kind == 0) begin
        c.srca = 1'b1;
        c.srcb = 2'b10;
        c.res  = 2'b10;
        c.irw  = e.mr;
        c.pcw  = e.mr;
      end else begin
        c.adr  = 1'b1;
        c.byt  = Funct[2];
        c.memw = (kind == 2);
      end
      c.flt = to && (i == n - 1);
      e.e1 = c;
      e.e0 = c;
      q.push_back(e);
    end
  endtask

  function automatic int pick_st();
    case ($urandom_range(0, 7))
      1: return 1;
      2: return 2;
      3: return 3;
      4: return 14;
      5: return 15;
      6: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic run(input logic [1:0] op, input logic [5:0] fn,
                     input logic [3:0] rd, input logic cx,
                     input int fst, input int mst);
    ctl_t c, c0;
    bit   to;
    logic [2:0] alu;
    logic [1:0] flw;
    logic cmp, ok, bad;
    Op = op;
    Funct = fn;
    Rd = rd;
    CondEx = cx;
    q.delete();
    mem_phase(0, fst, to);
    if (to) mem_phase(0, 0, to);
    ref_alu(fn, alu, flw, cmp, ok);
    bad = (op == 2'b11) || (op == 2'b00 && !ok);
    c = base();
    c.srca = 1'b1;
    c.srcb = 2'b10;
    c.ill  = cx && bad;
    push(c, c);
    if (cx && !bad) begin
      case (op)
        2'b00: begin
          c = base();
          c.srcb = fn[5] ? 2'b01 : 2'b00;
          c.alu = alu;
          c.flw = flw;
          push(c, c);
          if (!cmp) begin
            c = base();
            c.regw = 1'b1;
            c.pcw = (rd == 4'd15);
            push(c, c);
          end
        end
        2'b01: begin
          c = base();
          c.srcb = 2'b01;
          push(c, c);
          mem_phase(fn[0] ? 1 : 2, mst, to);
          if (fn[0] && !to) begin
            c = base();
            c.regw = 1'b1;
            c.res = 2'b01;
            c.byt = fn[2];
            c.pcw = (rd == 4'd15);
            push(c, c);
          end
        end
        default: begin
          c = base();
          c.srcb = 2'b01;
          c.res = 2'b10;
          c.pcw = 1'b1;
          c0 = c;
          c.regw = fn[4];
          c.link = fn[4];
          push(c, c0);
        end
      endcase
    end
    foreach (q[i]) begin
      MemReady = q[i].mr;
      @(negedge clk);
      chk($sformatf("i%0d c%0d bl1", ninstr, i), 32'(o1), 32'(q[i].e1));
      chk($sformatf("i%0d c%0d bl0", ninstr, i), 32'(o0), 32'(q[i].e0));
      @(posedge clk);
      #1;
    end
    ninstr++;
  endtask

  initial begin
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] rd;
    int r;
    Op = 2'b01;
    Funct = 6'b011101;
    MemReady = 1'b1;
    CondEx = 1'b1;
    #3;
    chk("rst_a", 32'(o1), 32'd0);
    chk("rst_b", 32'(o0), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", 32'(o1), 32'd0);
    reset = 1'b1;

    run(2'b00, 6'b001000, 4'd1, 1'b1, 0, 0);
    run(2'b00, 6'b010101, 4'd0, 1'b1, 0, 0);
    run(2'b01, 6'b011101, 4'd2, 1'b1, 0, 2);
    run(2'b10, 6'b010000, 4'd0, 1'b1, 0, 0);
    run(2'b00, 6'b001000, 4'd1, 1'b1, 15, 0);
    run(2'b11, 6'b000000, 4'd1, 1'b1, 0, 0);
    run(2'b00, 6'b001000, 4'd1, 1'b0, 0, 0);
    run(2'b01, 6'b011000, 4'd3, 1'b1, 14, 14);
    run(2'b01, 6'b011001, 4'd15, 1'b1, 1, 15);
    run(2'b00, 6'b111011, 4'd15, 1'b1, 0, 0);

    for (int n = 0; n < 250; n++) begin
      r  = $urandom_range(0, 19);
      op = (r < 10) ? 2'b00 : (r < 15) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
      fn = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 4) != 0)
        fn[4:1] = legal[$urandom_range(0, 5)];
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run(op, fn, rd, $urandom_range(0, 7) != 0, pick_st(), pick_st());
    end

    // abort a store mid-access
    Op = 2'b01;
    Funct = 6'b011000;
    Rd = 4'd0;
    CondEx = 1'b1;
    MemReady = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    MemReady = 1'b0;
    @(posedge clk);
    #1;
    chk("memwr_on", 32'(mw_a), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_memw", 32'(mw_a), 32'd0);
    chk("rst_all_a", 32'(o1), 32'd0);
    chk("rst_all_b", 32'(o0), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    MemReady = 1'b1;
    #1;
    chk("refetch", 32'({irw_a, pcw_a, sb_a}), 32'b1110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
